// File: rtl/active_debug_pkg.sv
// Shared types, constants and helpers for the ACTIVEPRO Active Debug Port arbiter
// and transmitter.
package active_debug_pkg;

  localparam int MSG_BYTES            = 64;
  localparam int CHAN_BITS            = 6;
  localparam int BITS_PER_BYTE_CYCLES = 16;
  localparam int HEADER_BYTES         = 2;
  localparam int CNT_BITS             = 12;

  typedef logic [MSG_BYTES-1:0][7:0] active_msg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  // First set request after `last`, wrapping modulo num_req; result is {valid, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int num_req);
    logic [3:0] res;
    int         idx;
    res = 4'd0;
    for (int k = num_req; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= num_req) idx = idx - num_req;
      if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

  // Serialization time of a packet with text length len, plus the guard gap.
  function automatic logic [CNT_BITS-1:0] hold_cycles(input logic [5:0] len, input int gap);
    return CNT_BITS'((int'(len) + HEADER_BYTES + 1) * BITS_PER_BYTE_CYCLES + gap);
  endfunction

endpackage

// File: rtl/active_msg_length.sv
// Combinational finder of the first zero byte in positions 1..63 of a debug message;
// valid is low when the message carries no terminator.
module active_msg_length
  import active_debug_pkg::*;
(
  input  active_msg_t msg,
  output logic [5:0]  len,
  output logic        valid
);

  // Scan downward so the lowest zero position is the one that sticks.
  always_comb begin
    len   = 6'd0;
    valid = 1'b0;
    for (int x = MSG_BYTES - 1; x >= 1; x--) begin
      if (msg[x] == 8'h00) begin
        len   = 6'(x);
        valid = 1'b1;
      end else begin
        len   = len;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/active_debug_arbiter.sv
// Round-robin arbiter sharing one Active Debug Port transmitter among NUM_REQ sources;
// validates the granted message and holds off new grants for its serialization time.
module active_debug_arbiter
  import active_debug_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                                        SYS_CLOCK,
  input  logic                                        RESET,
  input  logic [NUM_REQ-1:0]                          REQ,
  input  logic [NUM_REQ-1:0][MSG_BYTES-1:0][7:0]      REQ_MESSAGE,
  input  logic [NUM_REQ-1:0][CHAN_BITS-1:0]           REQ_CHANNEL,
  output logic [NUM_REQ-1:0]                          ACK,
  output logic                                        ERR,
  output active_msg_t                                 ACTIVE_MESSAGE,
  output logic [CHAN_BITS-1:0]                        ACTIVE_CHANNEL,
  output logic                                        ACTIVE_WR,
  output logic                                        BUSY,
  output logic [2:0]                                  GRANT_ID
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t             state_r;
  arb_state_t             state_next_s;
  logic [CNT_BITS-1:0]    cnt_r;
  logic [CNT_BITS-1:0]    cnt_next_s;
  logic [NUM_REQ-1:0]     ack_next_s;
  logic                   err_next_s;
  logic                   wr_next_s;
  logic                   busy_next_s;
  active_msg_t            msg_next_s;
  logic [CHAN_BITS-1:0]   chan_next_s;
  logic [2:0]             gid_next_s;
  logic [3:0]             pick_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic [5:0]             len_s;
  logic                   len_valid_s;

  assign pick_s     = rr_pick(8'(REQ), GRANT_ID, NUM_REQ);
  assign pick_idx_s = pick_s[IDX_W-1:0];

  active_msg_length u_len (
    .msg   (ACTIVE_MESSAGE),
    .len   (len_s),
    .valid (len_valid_s)
  );

  // Next-state, counter and output computation for the grant/check/strobe/hold sequence.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    ack_next_s   = '0;
    err_next_s   = 1'b0;
    wr_next_s    = 1'b0;
    msg_next_s   = ACTIVE_MESSAGE;
    chan_next_s  = ACTIVE_CHANNEL;
    gid_next_s   = GRANT_ID;
    case (state_r)
      IDLE: begin
        if (pick_s[3]) begin
          state_next_s = CHECK;
          msg_next_s   = REQ_MESSAGE[pick_idx_s];
          chan_next_s  = REQ_CHANNEL[pick_idx_s];
          gid_next_s   = pick_s[2:0];
          ack_next_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      CHECK: begin
        if (len_valid_s) begin
          state_next_s = STROBE;
          cnt_next_s   = hold_cycles(len_s, GAP_CYCLES);
        end else begin
          state_next_s = IDLE;
          err_next_s   = 1'b1;
        end
      end
      STROBE: begin
        state_next_s = HOLD;
        wr_next_s    = 1'b1;
      end
      HOLD: begin
        // The cycle that brings the count to zero is the last HOLD cycle.
        if (cnt_r <= 12'd1) begin
          state_next_s = IDLE;
          cnt_next_s   = 12'd0;
        end else begin
          cnt_next_s   = cnt_r - 12'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 12'd0;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State register and registered outputs with synchronous reset.
  always_ff @(posedge SYS_CLOCK) begin
    if (RESET) begin
      state_r        <= IDLE;
      cnt_r          <= 12'd0;
      ACK            <= '0;
      ERR            <= 1'b0;
      ACTIVE_WR      <= 1'b0;
      ACTIVE_MESSAGE <= '0;
      ACTIVE_CHANNEL <= 6'd0;
      BUSY           <= 1'b0;
      GRANT_ID       <= 3'(NUM_REQ - 1);
    end else begin
      state_r        <= state_next_s;
      cnt_r          <= cnt_next_s;
      ACK            <= ack_next_s;
      ERR            <= err_next_s;
      ACTIVE_WR      <= wr_next_s;
      ACTIVE_MESSAGE <= msg_next_s;
      ACTIVE_CHANNEL <= chan_next_s;
      BUSY           <= busy_next_s;
      GRANT_ID       <= gid_next_s;
    end
  end

endmodule

// File: tb/tb_active_debug_arbiter.sv
// Self-checking bench for active_debug_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level round-robin / hold-off model.
module tb_active_debug_arbiter;

  localparam int NR  = 4;
  localparam int GAP = 8;

  logic                      SYS_CLOCK = 1'b0;
  logic                      RESET;
  logic [NR-1:0]             REQ;
  logic [NR-1:0][63:0][7:0]  REQ_MESSAGE;
  logic [NR-1:0][5:0]        REQ_CHANNEL;
  logic [NR-1:0]             ACK;
  logic                      ERR;
  logic [63:0][7:0]          ACTIVE_MESSAGE;
  logic [5:0]                ACTIVE_CHANNEL;
  logic                      ACTIVE_WR;
  logic                      BUSY;
  logic [2:0]                GRANT_ID;

  int checks = 0;
  int errors = 0;

  active_debug_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
    .SYS_CLOCK      (SYS_CLOCK),
    .RESET          (RESET),
    .REQ            (REQ),
    .REQ_MESSAGE    (REQ_MESSAGE),
    .REQ_CHANNEL    (REQ_CHANNEL),
    .ACK            (ACK),
    .ERR            (ERR),
    .ACTIVE_MESSAGE (ACTIVE_MESSAGE),
    .ACTIVE_CHANNEL (ACTIVE_CHANNEL),
    .ACTIVE_WR      (ACTIVE_WR),
    .BUSY           (BUSY),
    .GRANT_ID       (GRANT_ID)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Model: text length is the first zero byte after byte 0; 0 means unterminated.
  function automatic int exp_len(input logic [63:0][7:0] m);
    int r = 0;
    for (int x = 1; x < 64; x++)
      if (r == 0 && m[x] == 8'h00) r = x;
    return r;
  endfunction

  function automatic int hold_of(input int len);
    return 16 * (len + 3) + GAP;
  endfunction

  function automatic int rr_model(input logic [NR-1:0] req, input int last);
    int r = -1;
    for (int k = 1; k <= NR; k++)
      if (r < 0 && req[(last + k) % NR]) r = (last + k) % NR;
    return r;
  endfunction

  task automatic tick();
    @(posedge SYS_CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ   = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // len 1..63 places the terminator at byte len; len 64 builds an unterminated message.
  task automatic make_msg(input int len, output logic [63:0][7:0] m);
    m[0] = 8'h00;
    for (int i = 1; i < 64; i++) begin
      if (i < len)       m[i] = 8'($urandom_range(1, 255));
      else if (i == len) m[i] = 8'h00;
      else               m[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic new_req(input int i);
    int r, len;
    logic [63:0][7:0] m;
    r = $urandom_range(0, 9);
    if (r == 0)      len = 64;
    else if (r == 1) len = 1;
    else if (r == 2) len = 63;
    else             len = $urandom_range(2, 40);
    make_msg(len, m);
    REQ_MESSAGE[i] = m;
    REQ_CHANNEL[i] = 6'($urandom_range(0, 63));
  endtask

  task automatic wait_ack(input int budget, output int w);
    w = 0;
    do begin
      tick();
      w++;
    end while (ACK == '0 && w < budget);
    if (ACK == '0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ACK after %0d cycles", w);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ   = 4'b1111;
    for (int i = 0; i < NR; i++) new_req(i);
    tick();
    tick();
    checks++; if (ACK !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ACK); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
    checks++; if (ACTIVE_WR !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", ACTIVE_WR); end
    checks++; if (ACTIVE_MESSAGE !== '0) begin errors++; $display("FAIL reset_msg: got %h want 0", ACTIVE_MESSAGE); end
    checks++; if (ACTIVE_CHANNEL !== 6'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", ACTIVE_CHANNEL); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (GRANT_ID !== 3'(NR - 1)) begin errors++; $display("FAIL reset_gid: got %0d want %0d", GRANT_ID, NR - 1); end
    RESET = 1'b0;
    REQ   = '0;
  endtask

  task automatic test_single();
    logic [63:0][7:0] m;
    int load, wr_extra;
    do_reset();
    m = '0;
    m[1] = 8'h48;
    m[2] = 8'h69;
    REQ_MESSAGE[0] = m;
    REQ_CHANNEL[0] = 6'd5;
    REQ = 4'b0001;
    tick();
    checks++; if (ACK !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ACK); end
    checks++; if (GRANT_ID !== 3'd0) begin errors++; $display("FAIL single_gid: got %0d want 0", GRANT_ID); end
    checks++; if (ACTIVE_MESSAGE !== m) begin errors++; $display("FAIL single_msg: got %h want %h", ACTIVE_MESSAGE, m); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy0: got %b want 1", BUSY); end
    REQ = '0;
    tick();
    checks++; if (ERR !== 1'b0 || ACTIVE_WR !== 1'b0) begin errors++; $display("FAIL single_cyc1: got err=%b wr=%b want 0 0", ERR, ACTIVE_WR); end
    tick();
    checks++; if (ACTIVE_WR !== 1'b1) begin errors++; $display("FAIL single_wr: got %b want 1 at cycle 2", ACTIVE_WR); end
    checks++; if (ACTIVE_CHANNEL !== 6'd5) begin errors++; $display("FAIL single_chan: got %0d want 5", ACTIVE_CHANNEL); end
    load = hold_of(exp_len(m));
    wr_extra = 0;
    for (int c = 3; c <= load + 3; c++) begin
      tick();
      if (ACTIVE_WR) wr_extra++;
      if (c == load + 1) begin
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b want 1 at cycle %0d", BUSY, c); end
      end
      if (c == load + 3) begin
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0 at cycle %0d", BUSY, c); end
      end
    end
    checks++; if (wr_extra != 0) begin errors++; $display("FAIL single_wr_once: got %0d extra strobes want 0", wr_extra); end
  endtask

  task automatic test_unterminated();
    logic [63:0][7:0] m;
    do_reset();
    make_msg(64, m);
    REQ_MESSAGE[2] = m;
    REQ = 4'b0100;
    tick();
    checks++; if (ACK !== 4'b0100 || ERR !== 1'b0) begin errors++; $display("FAIL unterm_ack: got ack=%b err=%b want 0100 0", ACK, ERR); end
    REQ = 4'b0000;
    tick();
    checks++; if (ERR !== 1'b1 || ACTIVE_WR !== 1'b0) begin errors++; $display("FAIL unterm_err: got err=%b wr=%b want 1 0", ERR, ACTIVE_WR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL unterm_idle: got busy=%b want 0", BUSY); end
    make_msg(5, m);
    REQ_MESSAGE[0] = m;
    REQ = 4'b0001;
    tick();
    checks++; if (ACK !== 4'b0001 || ERR !== 1'b0 || ACTIVE_WR !== 1'b0) begin
      errors++; $display("FAIL unterm_regrant: got ack=%b err=%b wr=%b want 0001 0 0", ACK, ERR, ACTIVE_WR);
    end
    REQ = '0;
  endtask

  task automatic test_contention();
    logic [63:0][7:0] m;
    int w, prev_load;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      make_msg($urandom_range(1, 20), m);
      REQ_MESSAGE[i] = m;
      REQ_CHANNEL[i] = 6'(i + 10);
    end
    REQ = 4'b1111;
    prev_load = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(1500, w);
      checks++; if (ACK !== 4'(1 << (k % NR))) begin errors++; $display("FAIL cont_order%0d: got %b want %b", k, ACK, 4'(1 << (k % NR))); end
      if (k > 0) begin
        checks++; if (w != prev_load + 3) begin errors++; $display("FAIL cont_spacing%0d: got %0d want %0d", k, w, prev_load + 3); end
      end
      prev_load = hold_of(exp_len(REQ_MESSAGE[k % NR]));
    end
    REQ = '0;
  endtask

  task automatic test_withdraw();
    logic [63:0][7:0] m;
    int load, w;
    do_reset();
    make_msg($urandom_range(1, 20), m);
    REQ_MESSAGE[0] = m;
    make_msg(4, m);
    REQ_MESSAGE[2] = m;
    make_msg(7, m);
    REQ_MESSAGE[3] = m;
    REQ = 4'b0001;
    tick();
    load = hold_of(exp_len(REQ_MESSAGE[0]));
    REQ = 4'b0000;
    for (int c = 1; c <= 3; c++) tick();
    REQ = 4'b0100;
    tick();
    REQ = 4'b0000;
    for (int c = 5; c <= 10; c++) tick();
    REQ = 4'b1000;
    wait_ack(1500, w);
    checks++; if (ACK !== 4'b1000) begin errors++; $display("FAIL withdraw_ack: got %b want 1000", ACK); end
    checks++; if (w != load + 3 - 10) begin errors++; $display("FAIL late_grant_time: got %0d want %0d", w, load + 3 - 10); end
    checks++; if (GRANT_ID !== 3'd3) begin errors++; $display("FAIL late_gid: got %0d want 3", GRANT_ID); end
    REQ = '0;
  endtask

  task automatic test_reset_mid_hold();
    logic [63:0][7:0] m;
    do_reset();
    make_msg(3, m);
    REQ_MESSAGE[0] = m;
    REQ_CHANNEL[0] = 6'd33;
    REQ = 4'b0001;
    tick();
    REQ = 4'b0000;
    for (int c = 1; c <= 56; c++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    make_msg(9, m);
    REQ_MESSAGE[1] = m;
    REQ_CHANNEL[1] = 6'd17;
    REQ = 4'b0010;
    checks++; if (ACK !== 4'b0000 || ERR !== 1'b0 || ACTIVE_WR !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses: got ack=%b err=%b wr=%b want 0000 0 0", ACK, ERR, ACTIVE_WR);
    end
    checks++; if (BUSY !== 1'b0 || GRANT_ID !== 3'(NR - 1)) begin errors++; $display("FAIL midrst_state: got busy=%b gid=%0d want 0 %0d", BUSY, GRANT_ID, NR - 1); end
    checks++; if (ACTIVE_MESSAGE !== '0 || ACTIVE_CHANNEL !== 6'd0) begin errors++; $display("FAIL midrst_data: got chan=%0d msg=%h want 0", ACTIVE_CHANNEL, ACTIVE_MESSAGE); end
    tick();
    checks++; if (ACK !== 4'b0010 || GRANT_ID !== 3'd1) begin errors++; $display("FAIL midrst_regrant: got ack=%b gid=%0d want 0010 1", ACK, GRANT_ID); end
    checks++; if (ACTIVE_CHANNEL !== 6'd17) begin errors++; $display("FAIL midrst_chan: got %0d want 17", ACTIVE_CHANNEL); end
    REQ = '0;
  endtask

  task automatic test_max_len();
    logic [63:0][7:0] m0, m1;
    int c, bad, wrs, load;
    do_reset();
    make_msg(63, m0);
    make_msg(2, m1);
    REQ_MESSAGE[0] = m0;
    REQ_MESSAGE[1] = m1;
    REQ = 4'b0011;
    tick();
    checks++; if (ACK !== 4'b0001) begin errors++; $display("FAIL maxlen_ack: got %b want 0001", ACK); end
    REQ = 4'b0010;
    load = 1056 + GAP;
    c = 0; bad = 0; wrs = 0;
    do begin
      tick();
      c++;
      if (ACK == '0 && ACTIVE_MESSAGE !== m0) bad++;
      if (ACTIVE_WR) wrs++;
      if (c == 2) begin
        checks++; if (ACTIVE_WR !== 1'b1) begin errors++; $display("FAIL maxlen_wr: got %b want 1 at cycle 2", ACTIVE_WR); end
      end
    end while (ACK == '0 && c < 1500);
    checks++; if (ACK !== 4'b0010) begin errors++; $display("FAIL maxlen_next_ack: got %b want 0010", ACK); end
    checks++; if (c != load + 3) begin errors++; $display("FAIL maxlen_holdoff: got %0d want %0d", c, load + 3); end
    checks++; if (bad != 0 || wrs != 1) begin errors++; $display("FAIL maxlen_stable: got %0d unstable cycles, %0d strobes want 0, 1", bad, wrs); end
    REQ = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] pending;
    int last, exp_id, w, gap, len, j;
    do_reset();
    last = NR - 1;
    pending = '0;
    for (int i = 0; i < NR; i++)
      if ($urandom_range(0, 1) == 1) begin new_req(i); pending[i] = 1'b1; end
    if (pending == '0) begin new_req(0); pending[0] = 1'b1; end
    REQ = pending;
    gap = 1;
    for (int t = 0; t < 25; t++) begin
      exp_id = rr_model(pending, last);
      wait_ack(1500, w);
      checks++; if (ACK !== 4'(1 << exp_id)) begin errors++; $display("FAIL rand_winner%0d: got %b want %b", t, ACK, 4'(1 << exp_id)); end
      checks++; if (w != gap) begin errors++; $display("FAIL rand_gap%0d: got %0d want %0d", t, w, gap); end
      checks++; if (ACTIVE_MESSAGE !== REQ_MESSAGE[exp_id] || ACTIVE_CHANNEL !== REQ_CHANNEL[exp_id]) begin
        errors++; $display("FAIL rand_data%0d: got chan=%0d want %0d", t, ACTIVE_CHANNEL, REQ_CHANNEL[exp_id]);
      end
      last = exp_id;
      pending[exp_id] = 1'b0;
      len = exp_len(REQ_MESSAGE[exp_id]);
      for (int i = 0; i < NR; i++)
        if (!pending[i] && $urandom_range(0, 2) == 0) begin new_req(i); pending[i] = 1'b1; end
      if (pending == '0) begin j = $urandom_range(0, NR - 1); new_req(j); pending[j] = 1'b1; end
      REQ = pending;
      tick();
      checks++; if (ERR !== 1'(len == 0) || ACTIVE_WR !== 1'b0) begin
        errors++; $display("FAIL rand_check%0d: got err=%b wr=%b want %b 0", t, ERR, ACTIVE_WR, 1'(len == 0));
      end
      if (len == 0) begin
        gap = 1;
      end else begin
        tick();
        checks++; if (ACTIVE_WR !== 1'b1) begin errors++; $display("FAIL rand_wr%0d: got %b want 1", t, ACTIVE_WR); end
        gap = hold_of(len) + 1;
      end
    end
    REQ = '0;
  endtask

  initial begin
    RESET = 1'b1;
    REQ = '0;
    REQ_MESSAGE = '0;
    REQ_CHANNEL = '0;
    test_reset();
    test_single();
    test_unterminated();
    test_contention();
    test_withdraw();
    test_reset_mid_hold();
    test_max_len();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/active_debug_arbiter.md
Name: active_debug_arbiter

Overview:
- Shares one ACTIVEPRO Active Debug Port transmitter among NUM_REQ requesters using round-robin arbitration.
- On grant, latches the winner's zero-surrounded message and channel, validates it, and issues a one-cycle ACTIVE_WR.
- Holds the outputs stable and blocks new grants until the transmitter's computed serialization time, plus a guard gap, has elapsed.
- Sits between debug-message sources (CPU shim, FSM probes) and the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 8, idle SYS_CLOCK cycles inserted after each packet's hold-off (1..255).

Ports:
- SYS_CLOCK  in  1  system clock; the transmitter runs on the same clock.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_REQ  per-requester send request, level; held until ACK.
- REQ_MESSAGE  in  [NUM_REQ][64][8]  per-requester message; byte 0 = 0, text, 0 terminator.
- REQ_CHANNEL  in  [NUM_REQ][6]  per-requester channel.
- ACK  out  NUM_REQ  one-hot, one-cycle pulse: the request was accepted (sent or rejected).
- ERR  out  1  one-cycle pulse coincident with ACK when the message was rejected.
- ACTIVE_MESSAGE  out  [64][8]  to transmitter; latched message.
- ACTIVE_CHANNEL  out  6  to transmitter.
- ACTIVE_WR  out  1  to transmitter; one-cycle strobe.
- BUSY  out  1  high in every state except IDLE.
- GRANT_ID  out  3  index of the last granted requester.

Behaviour:
- Reset values: ACK=0, ERR=0, ACTIVE_WR=0, ACTIVE_MESSAGE=0, ACTIVE_CHANNEL=0, BUSY=0, GRANT_ID=NUM_REQ-1 (so requester 0 has first priority), state=IDLE, counters=0.
- States: IDLE, CHECK, STROBE, HOLD.
- IDLE: if any REQ bit is high, pick the first set bit searching from GRANT_ID+1 with wrap-around. Then, on the same edge:
  - latch that requester's message and channel into ACTIVE_MESSAGE/ACTIVE_CHANNEL;
  - set GRANT_ID;
  - pulse ACK[id];
  - go to CHECK.
- CHECK (1 cycle): L = smallest x in 1..63 with ACTIVE_MESSAGE[x]==0.
  - If no such x: pulse ERR, go to IDLE. No ACTIVE_WR is issued. (The ERR pulse is one cycle after ACK; rejected messages are never sent.)
  - Otherwise: load HOLD counter with 16*(L+3)+GAP_CYCLES, go to STROBE.
- STROBE (1 cycle): ACTIVE_WR=1, go to HOLD.
- HOLD: decrement the counter each cycle; on reaching 0, go to IDLE.
  - Counter is 12 bits; maximum load is 16*66+255 = 1311.
- Latency: grant to ACTIVE_WR = 2 cycles.
- ACK pulses on the grant edge. ERR pulses in CHECK when the message is rejected; this correction to the ACK/ERR timing is binding.
- ACTIVE_MESSAGE and ACTIVE_CHANNEL change only on a grant edge. They stay stable through STROBE and HOLD.
- Requesters may deassert REQ or change REQ_MESSAGE after ACK. Inputs are not sampled outside IDLE.
- A REQ withdrawn before grant is never ACKed and leaves no side effects.
- Simultaneous requests: strict round-robin. The requester just served has lowest priority at the next IDLE.
- L=1 (empty text) is valid: hold-off = 64+GAP_CYCLES.
- The channel is passed through unmodified; the transmitter masks it.
- RESET mid-operation: return to IDLE with reset values next cycle, no ACK/ERR/WR. The transmitter is reset by the same RESET.
- REQ bits at index >= NUM_REQ do not exist. GRANT_ID wraps modulo NUM_REQ.

Decomposition:
- Package active_debug_pkg:
  - constants MSG_BYTES=64, CHAN_BITS=6, BITS_PER_BYTE_CYCLES=16, HEADER_BYTES=2;
  - typedef active_msg_t ([64][8]);
  - state enum arb_state_t {IDLE, CHECK, STROBE, HOLD}.
- One sub-module: active_msg_length (combinational first-zero finder over bytes 1..63). Outputs: 6-bit L and a valid flag. The transmitter can reuse it later.
- Round-robin picker and HOLD counter are inline.

Test Plan:
- Single request: REQ=0001, message bytes 0,'H','i',0 (L=3), channel 5, GAP_CYCLES=8.
  - ACK=0001 at cycle 0; ACTIVE_WR at cycle 2, ACTIVE_CHANNEL=5.
  - HOLD lasts 104 cycles; BUSY low at cycle 107.
  - Transmitter output decodes 0x7F, 0x45, then text.
- Contention: REQ=1111 held continuously.
  - Grants in order 0,1,2,3,0.
  - Each ACTIVE_WR is separated by exactly 3+16*(L+3)+GAP_CYCLES cycles.
- Unterminated message: all 64 bytes nonzero except byte 0.
  - ACK pulses, then ERR pulses the next cycle.
  - No ACTIVE_WR; back in IDLE 2 cycles after grant.
- Withdraw and late request:
  - REQ[2] is high for 1 cycle while busy serving 0, then drops: it is never ACKed.
  - REQ[3] is raised during HOLD: granted on the first IDLE cycle.
- Reset mid-HOLD: assert RESET for 1 cycle at count 50.
  - Next cycle all outputs are at reset values; GRANT_ID=NUM_REQ-1.
  - A new REQ=0010 is granted 1 cycle after RESET falls.
- Max length: L=63.
  - Hold-off = 1056+GAP_CYCLES.
  - ACTIVE_MESSAGE is unchanged throughout; no counter overflow.
